// File: rtl/jarch_pkg.sv
// Shared encodings for the JophArch sequencer: instruction type codes,
// execution-unit indices, fault codes and the control state type.
package jarch_pkg;

  localparam logic [2:0] TYPE_SYS   = 3'b000;
  localparam logic [2:0] TYPE_STACK = 3'b001;
  localparam logic [2:0] TYPE_ALU1  = 3'b010;
  localparam logic [2:0] TYPE_ALU2  = 3'b011;
  localparam logic [2:0] TYPE_DMA   = 3'b100;
  localparam logic [2:0] TYPE_JMP   = 3'b111;

  localparam logic [4:0] FUNC_HALT = 5'b11111;

  localparam int unsigned NUM_UNITS = 5;
  localparam logic [2:0] UNIT_ALU1  = 3'd0;
  localparam logic [2:0] UNIT_ALU2  = 3'd1;
  localparam logic [2:0] UNIT_DMA   = 3'd2;
  localparam logic [2:0] UNIT_STACK = 3'd3;
  localparam logic [2:0] UNIT_JMP   = 3'd4;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED,
    ST_FAULT
  } state_e;

  typedef struct packed {
    logic       is_unit;
    logic [2:0] unit;
  } unit_sel_t;

  // Maps a type field to the execution unit it dispatches to, if any.
  function automatic unit_sel_t unit_of_type(input logic [2:0] t);
    unit_sel_t s;
    s.is_unit = 1'b1;
    s.unit    = UNIT_ALU1;
    case (t)
      TYPE_ALU1:  s.unit = UNIT_ALU1;
      TYPE_ALU2:  s.unit = UNIT_ALU2;
      TYPE_DMA:   s.unit = UNIT_DMA;
      TYPE_STACK: s.unit = UNIT_STACK;
      TYPE_JMP:   s.unit = UNIT_JMP;
      default:    s.is_unit = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/jarch_sequencer_if.sv
// Instruction-memory and execution-unit handshake bundle of the sequencer.
interface jarch_sequencer_if
  import jarch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 24
);
  logic                 imem_req;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic                 imem_ready;
  logic [31:0]          imem_rdata;
  logic [NUM_UNITS-1:0] unit_start;
  logic [NUM_UNITS-1:0] unit_done;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;

  modport master (
    output imem_req, imem_addr, unit_start,
    input  imem_ready, imem_rdata, unit_done, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, unit_start,
    output imem_ready, imem_rdata, unit_done, branch_taken, branch_target
  );
endinterface

// File: rtl/seq_watchdog.sv
// Loadable down-counter bounding how long the sequencer waits for a unit.
// TIMEOUT of 0 never expires.
module seq_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CW'(TIMEOUT);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires in the last permitted wait cycle so the fault lands TIMEOUT cycles after start.
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == CW'(1));
endmodule

// File: rtl/jarch_sequencer.sv
// Fetch/decode/dispatch controller: owns pc, ir, halt/fault state and the
// retired-instruction counter; dispatches each word to one execution unit.
module jarch_sequencer
  import jarch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 24,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         TIMEOUT  = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  jarch_sequencer_if.master   bus,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [31:0]         retired_count
);
  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, retire_pc;
  logic [31:0]         ir_q, ir_d, retired_q, retired_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic                first_q, first_d;
  logic                run_q;
  logic                retire, is_halt;
  logic                wd_clear, wd_expired;
  unit_sel_t           sel;
  logic                sel_done;

  assign sel      = unit_of_type(ir_q[31:29]);
  assign sel_done = bus.unit_done[sel.unit];

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (state_q == ST_EXEC),
    .expired (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retired_d    = retired_q;
    fault_code_d = fault_code_q;
    first_d      = 1'b0;
    wd_clear     = 1'b0;
    retire       = 1'b0;
    is_halt      = 1'b0;
    retire_pc    = pc_q + PC_WIDTH'(1);
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (sel.is_unit) begin
          state_d  = ST_EXEC;
          first_d  = 1'b1;
          wd_clear = 1'b1;
        end else if (ir_q[31:29] == TYPE_SYS) begin
          retire  = 1'b1;
          is_halt = (ir_q[28:24] == FUNC_HALT);
          if (is_halt) retire_pc = pc_q;
        end else begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_ILLEGAL;
        end
      end
      ST_EXEC: begin
        // A completion in the watchdog's last cycle still retires.
        if (!first_q && sel_done) begin
          retire = 1'b1;
          if ((sel.unit == UNIT_JMP) && bus.branch_taken) retire_pc = bus.branch_target;
        end else if (wd_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = FAULT_TIMEOUT;
        end
      end
      ST_HALTED: begin
        if (run && !run_q) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
    if (retire) begin
      retired_d = retired_q + 32'd1;
      pc_d      = retire_pc;
      state_d   = is_halt ? ST_HALTED : (run ? ST_FETCH : ST_IDLE);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      retired_q    <= '0;
      fault_code_q <= FAULT_NONE;
      first_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retired_q    <= retired_d;
      fault_code_q <= fault_code_d;
      first_q      <= first_d;
      run_q        <= run;
    end
  end

  always_comb begin
    bus.unit_start = '0;
    if ((state_q == ST_EXEC) && first_q) bus.unit_start[sel.unit] = 1'b1;
  end

  assign bus.imem_req   = (state_q == ST_FETCH);
  assign bus.imem_addr  = pc_q;
  assign ir             = ir_q;
  assign pc             = pc_q;
  assign halted         = (state_q == ST_HALTED);
  assign fault          = (state_q == ST_FAULT);
  assign fault_code     = fault_code_q;
  assign retired_count  = retired_q;
endmodule

// File: tb/tb_jarch_sequencer.sv
// Directed plus randomized bench for jarch_sequencer against an
// instruction-level reference model of pc / retire / halt / fault behaviour.
module tb_jarch_sequencer;
  localparam int unsigned PCW = 24;
  localparam int unsigned TO  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            run   = 1'b0;
  logic [31:0]     ir, retired_count;
  logic [PCW-1:0]  pc;
  logic            halted, fault;
  logic [1:0]      fault_code;

  int unsigned     n_cmp = 0;
  int unsigned     n_bad = 0;
  logic [PCW-1:0]  exp_pc;
  logic [31:0]     exp_ret;

  // unit index dispatched for each 3-bit type; -1 = no unit (SYS or illegal)
  int              unit_tab [8] = '{-1, 3, 0, 1, 2, -1, -1, 4};
  logic [2:0]      legal_types [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  jarch_sequencer_if #(.PC_WIDTH(PCW)) bus ();

  jarch_sequencer #(
    .PC_WIDTH (PCW),
    .RESET_PC (24'h000000),
    .TIMEOUT  (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .bus           (bus),
    .ir            (ir),
    .pc            (pc),
    .halted        (halted),
    .fault         (fault),
    .fault_code    (fault_code),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PCW-1:0] pc_inc(input logic [PCW-1:0] p);
    longint unsigned m;
    m = longint'(1) << PCW;
    return PCW'((longint'(p) + 1) % m);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_start", bus.unit_start, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_fcode", fault_code, 0);
    chk("rst_flags", {halted, fault}, 0);
    bus.imem_ready = 1'b0;
    bus.unit_done  = '0;
    tick();
    reset   = 1'b0;
    run     = 1'b1;
    exp_pc  = '0;
    exp_ret = '0;
    tick();
  endtask

  // Runs one instruction starting in FETCH. done_dly = cycles after the start
  // pulse at which the unit answers; 0 means it never answers.
  task automatic exec_instr(input logic [31:0] word, input int mem_wait, input int done_dly,
                            input logic taken, input logic [PCW-1:0] tgt, input logic run_after);
    int   u;
    logic is_halt;
    logic [2:0] t;
    logic [4:0] f;
    logic [4:0] sel_mask;
    t = word[31:29];
    f = word[28:24];
    u = unit_tab[t];
    is_halt = (t == 3'd0) && (f == 5'h1F);
    chk("fetch_req", bus.imem_req, 1);
    chk("fetch_addr", bus.imem_addr, exp_pc);
    for (int w = 0; w < mem_wait; w++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = $urandom;
      run = 1'($urandom_range(0, 1));
      tick();
      chk("wait_req", bus.imem_req, 1);
      chk("wait_addr", bus.imem_addr, exp_pc);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = $urandom;
    chk("ir_load", ir, word);
    chk("decode_req", bus.imem_req, 0);
    if (u >= 0) begin
      sel_mask = 5'(1 << u);
      run = 1'($urandom_range(0, 1));
      tick();
      chk("start_pulse", bus.unit_start, sel_mask);
      bus.unit_done     = sel_mask | 5'($urandom);
      bus.branch_taken  = 1'($urandom);
      bus.branch_target = PCW'($urandom);
      tick();
      if (done_dly == 0) begin
        for (int d = 1; d < int'(TO); d++) begin
          chk("wd_wait_fault", fault, 0);
          chk("wd_wait_start", bus.unit_start, 0);
          bus.unit_done = 5'b00001 | (5'($urandom) & ~sel_mask);
          tick();
        end
        bus.unit_done = '0;
        chk("wd_fault", fault, 1);
        chk("wd_code", fault_code, 2'b10);
        chk("wd_pc", pc, exp_pc);
        chk("wd_retired", retired_count, exp_ret);
        return;
      end
      for (int d = 1; d < done_dly; d++) begin
        chk("exec_start_low", bus.unit_start, 0);
        chk("exec_pc_hold", pc, exp_pc);
        bus.unit_done = 5'($urandom) & ~sel_mask;
        run = 1'($urandom_range(0, 1));
        tick();
      end
      chk("exec_start_low", bus.unit_start, 0);
      bus.unit_done     = sel_mask | 5'($urandom);
      bus.branch_taken  = taken;
      bus.branch_target = tgt;
      run = run_after;
      tick();
      bus.unit_done = '0;
      exp_ret++;
      exp_pc = (u == 4 && taken) ? tgt : pc_inc(exp_pc);
    end else if (t == 3'd0) begin
      run = run_after;
      tick();
      exp_ret++;
      if (!is_halt) exp_pc = pc_inc(exp_pc);
    end else begin
      tick();
      chk("ill_fault", fault, 1);
      chk("ill_code", fault_code, 2'b01);
      chk("ill_pc", pc, exp_pc);
      chk("ill_retired", retired_count, exp_ret);
      chk("ill_start", bus.unit_start, 0);
      return;
    end
    chk("retire_pc", pc, exp_pc);
    chk("retire_count", retired_count, exp_ret);
    chk("retire_fault", fault, 0);
    if (is_halt) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", bus.imem_req, 0);
      run = 1'b0;
      tick();
      chk("halt_stay", halted, 1);
      run = 1'b1;
      tick();
      exp_pc = pc_inc(exp_pc);
      chk("halt_leave", halted, 0);
      chk("halt_leave_pc", pc, exp_pc);
    end else if (!run_after) begin
      chk("idle_req", bus.imem_req, 0);
      chk("idle_halted", halted, 0);
      tick();
      chk("idle_stay", bus.imem_req, 0);
      run = 1'b1;
      tick();
    end
  endtask

  task automatic check_sticky_fault(input logic [1:0] code);
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom_range(0, 1));
      bus.unit_done = 5'($urandom);
      tick();
      chk("fault_sticky", {fault, fault_code}, {1'b1, code});
      chk("fault_pc_kept", pc, exp_pc);
    end
    bus.unit_done = '0;
  endtask

  initial begin
    logic [31:0]    w;
    logic [2:0]     tp;
    logic [PCW-1:0] rt;
    bus.imem_ready    = 1'b0;
    bus.imem_rdata    = '0;
    bus.unit_done     = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    #2;
    do_reset();

    // program [ALU1, NOP, HALT]
    exec_instr(32'h4012_3456, 0, 1, 1'b0, '0, 1'b1);
    exec_instr(32'h0A00_0000, 0, 1, 1'b0, '0, 1'b1);
    exec_instr(32'h1F00_0000, 0, 1, 1'b0, '0, 1'b1);
    chk("prog_retired", retired_count, 3);
    // pc 3,4 -> 5, then branches
    exec_instr(32'h0000_0001, 0, 1, 1'b0, '0, 1'b1);
    exec_instr(32'h0300_0000, 0, 1, 1'b0, '0, 1'b1);
    exec_instr(32'hE000_0000, 1, 2, 1'b1, 24'h000100, 1'b1);
    chk("jmp_taken_addr", bus.imem_addr, 24'h000100);
    exec_instr(32'hE100_0000, 0, 3, 1'b0, 24'h00ABCD, 1'b1);
    chk("jmp_not_taken_addr", bus.imem_addr, 24'h000101);
    exec_instr(32'h6000_0000, 3, 1, 1'b1, 24'h777777, 1'b1);
    exec_instr(32'hE000_0000, 0, 1, 1'b1, 24'hFFFFFF, 1'b1);
    exec_instr(32'h0000_0000, 0, 1, 1'b0, '0, 1'b1);
    chk("pc_wrap", pc, 24'h000000);

    for (int n = 0; n < 60; n++) begin
      tp = legal_types[$urandom_range(0, 5)];
      w  = {tp, 29'($urandom)};
      if (tp == 3'd0) begin
        w[28:24] = ($urandom_range(0, 4) == 0) ? 5'h1F : 5'(n % 31);
      end
      rt = PCW'($urandom);
      exec_instr(w, $urandom_range(0, 3), $urandom_range(1, TO - 1),
                 1'($urandom), rt, 1'($urandom_range(0, 3) != 0));
    end

    // asynchronous reset in the start cycle of an instruction
    exec_instr(32'h0000_0000, 0, 1, 1'b0, '0, 1'b1);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h6000_0042;
    tick();
    bus.imem_ready = 1'b0;
    tick();
    chk("pre_reset_start", bus.unit_start, 5'b00010);
    chk("pre_reset_pc", pc == 0, 0);
    do_reset();

    // DMA unit never answers
    exec_instr(32'h8000_0000, 0, 0, 1'b0, '0, 1'b1);
    check_sticky_fault(2'b10);
    do_reset();

    // illegal types 101 and 110
    exec_instr(32'h0000_0000, 0, 1, 1'b0, '0, 1'b1);
    exec_instr(32'hA000_0000, 0, 1, 1'b0, '0, 1'b1);
    check_sticky_fault(2'b01);
    do_reset();
    exec_instr({3'b110, 29'($urandom)}, 2, 1, 1'b0, '0, 1'b1);
    check_sticky_fault(2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jarch_sequencer.md
# jarch_sequencer

Multi-cycle fetch/decode/dispatch controller for the JophArch core. Fetches 32-bit instruction words from instruction memory into an instruction register, classifies each word by its 3-bit type field and hands it to exactly one execution unit (ALU1, ALU2, DMA, STACK, JMP) through a start/done handshake. It owns the program counter, halt/fault handling and a retired-instruction counter. It sits between instruction memory and the execution units; the register-field decode of the instruction register happens downstream.

## Interface
- `PC_WIDTH`, 24: program counter width; matches the 24-bit immediate jump target.
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 255: maximum cycles to wait for `unit_done`; 0 disables the watchdog.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; permits starting or continuing execution at instruction boundaries.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  PC_WIDTH  fetch address; equals `pc`.
- `imem_ready`  in  1  fetch accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `ir`  out  32  instruction register, driven to the downstream decode.
- `unit_start`  out  5  one-hot one-cycle start pulse. Bit order: 0 ALU1, 1 ALU2, 2 DMA, 3 STACK, 4 JMP.
- `unit_done`  in  5  per-unit completion, same bit order.
- `branch_taken`  in  1  JMP unit result; sampled with `unit_done[4]`.
- `branch_target`  in  PC_WIDTH  JMP target; sampled with `unit_done[4]`.
- `pc`  out  PC_WIDTH  current program counter.
- `halted`  out  1  high in HALTED.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  01 illegal type, 10 unit timeout, 00 none.
- `retired_count`  out  32  instructions retired; wraps.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
- Reset values: `pc`=RESET_PC, `ir`=0, `retired_count`=0, `fault_code`=0, state IDLE. All other outputs are low.
- IDLE: go to FETCH when `run`=1.
- FETCH: assert `imem_req`. On `imem_ready`, load `ir` from `imem_rdata` and go to DECODE. Hold `imem_req` until `imem_ready`.
- DECODE: type = `ir[31:29]`, func = `ir[28:24]`.
  - Type 010, 011, 100, 001, 111: go to EXEC, selecting unit ALU1, ALU2, DMA, STACK, JMP respectively.
  - Type 000 with func 11111 (HALT): retire and go to HALTED. `pc` is not advanced.
  - Type 000 with any other func (NOP): retire and advance `pc`.
  - Type 101 or 110: go to FAULT with code 01. Nothing is retired.
- EXEC:
  - `unit_start[sel]` is high only in the first EXEC cycle.
  - From the next cycle on, wait for `unit_done[sel]`. Done bits of non-selected units are ignored.
  - On done: retire. `pc` becomes `branch_target` if sel=JMP and `branch_taken`=1, otherwise `pc`+1.
  - If TIMEOUT≠0 and done is not seen within TIMEOUT cycles after start, go to FAULT with code 10.
- Retire: `retired_count`+1. Next state is FETCH if `run`=1, else IDLE. Exception: HALT always goes to HALTED.
- HALTED: leave to FETCH on a rising edge of `run` (0 in the previous cycle, 1 now), with `pc`+1.
- FAULT: sticky until `reset`. `pc` and `ir` keep the faulting instruction.
- Arithmetic: `pc`+1 wraps modulo 2^PC_WIDTH. `retired_count` wraps modulo 2^32.

## Timing
- FETCH: 1 cycle minimum, plus memory wait cycles.
- DECODE: always 1 cycle.
- EXEC: ≥2 cycles (start cycle, then done no earlier than the next cycle).
- Minimum instruction times: unit instruction 4 cycles; NOP and HALT 2 cycles.
- `pc`, `retired_count` and state update on the edge closing the retire cycle.
- `run` is only sampled at IDLE, at retire and in HALTED. Deasserting it mid-instruction does not abort the instruction.
- Asynchronous `reset` mid-FETCH or mid-EXEC drops `imem_req` and `unit_start` immediately and returns all registers to their reset values.
- `unit_done` asserted in the start cycle is ignored.
- The watchdog counter clears on every entry to EXEC.

## Structure
- Package `jarch_pkg` holds:
  - type codes (TYPE_STACK=001, TYPE_ALU1=010, TYPE_ALU2=011, TYPE_DMA=100, TYPE_JMP=111, TYPE_SYS=000);
  - FUNC_HALT=11111;
  - unit index constants;
  - the state enum;
  - fault code constants.
- One sub-module, `seq_watchdog`: a loadable down-counter with clear, enable and expire outputs, parameterised by TIMEOUT.

## Test plan
- Reset, `run`=1, memory ready every cycle, program [ALU1, NOP, HALT]; ALU1 done 1 cycle after start → `unit_start`=00001 once; `pc` 0→1→2; HALTED at cycle 8; `retired_count`=3.
- JMP at pc=5 with `branch_taken`=1, target=0x000100 → next `imem_addr`=0x000100. With `branch_taken`=0 → next `imem_addr`=6.
- Fetch word 0xA0000000 (type 101) → `fault`=1, `fault_code`=01, `pc` unchanged, `retired_count` unchanged, no `unit_start` pulse.
- TIMEOUT=4, DMA unit never answers → FAULT with code 10 exactly 4 cycles after the start pulse. A spurious `unit_done`=00001 during the wait is ignored.
- `imem_ready` withheld 3 cycles → `imem_req` held and `imem_addr` stable for 4 cycles. Reset pulse mid-EXEC → `unit_start`=0 and `pc`=RESET_PC immediately.
- `pc`=0xFFFFFF executing NOP → `pc` wraps to 0x000000.
